lcd_grid_update_arbiter: RTL and testbench
==========================================

# lcd_grid_update_arbiter

Owns the 12-column × 8-row overlay bit grid consumed by the LCD timing controller (column c drives that controller's per-column 8-bit mask input; row bit r gates the pixel). Two requesters share the grid: the touch-draw port (A) and the recognition/host port (B). Port B can also clear the whole grid. Writes land in a shadow grid. The shadow is copied to the displayed grid once per frame, at the start of vertical sync, so the panel never shows a torn or half-cleared grid.

## Interface
- COLS, 12, number of grid columns
- ROWS, 8, number of grid rows (bits per column)
- iCLK  in  1  LCD display clock
- iRST  in  1  synchronous, active-high reset
- iVD  in  1  LCD vertical sync from the timing controller; active low, one line long per frame
- iA_REQ  in  1  port A write request; held with its fields until oA_ACK is seen
- iA_COL  in  4  port A column index
- iA_ROW  in  3  port A row index
- iA_VAL  in  1  port A bit value
- oA_ACK  out  1  one-cycle pulse: port A request consumed
- iB_REQ  in  1  port B request; same hold rule as port A
- iB_CLR  in  1  qualifies iB_REQ; 1 = clear the entire grid, and iB_COL/ROW/VAL are ignored
- iB_COL  in  4  port B column index
- iB_ROW  in  3  port B row index
- iB_VAL  in  1  port B bit value
- oB_ACK  out  1  one-cycle pulse: port B request consumed (for a clear, when the clear completes)
- oGRID  out  96  displayed grid; column c occupies bits [8c+7:8c], row r is bit 8c+r
- oBUSY  out  1  high while a clear is in progress
- oCOMMIT  out  1  one-cycle pulse in the cycle after oGRID is loaded from the shadow

## Operation
- States:
  - IDLE: arbitrates single-cell writes and accepts clears.
  - CLEAR: walks columns 0..COLS-1, zeroing one shadow column per cycle.
- Eligibility: a port is eligible when its REQ is high and its ACK is currently low. This prevents a double grant while the requester is still dropping REQ.
- Arbitration, IDLE only, at most one grant per cycle:
  - If one port is eligible, it wins.
  - If both are eligible, the port not granted last wins (round-robin).
  - The pointer resets to favour A.
- Single-cell grant: the shadow bit [8·COL+ROW] ← VAL on the granting edge, and the port's ACK is high for the following cycle.
  - COL ≥ COLS: the request is still acked, but the shadow is unchanged.
- Clear grant (B with iB_CLR=1): go to CLEAR with column counter 0, oBUSY ← 1, no ACK yet.
  - Each CLEAR cycle zeroes shadow column cnt.
  - On the edge that zeroes column COLS-1: go to IDLE, oBUSY ← 0, oB_ACK pulses for the next cycle.
  - No port-A grants while in CLEAR. Port A is not starved afterwards: the pointer now favours A.
- Frame detect: vd_q is the registered iVD. Frame start = vd_q & ~iVD.
- Commit, in IDLE:
  - On a frame-start edge, oGRID ← shadow value from before that edge.
  - A write landing on the same edge appears in the next frame.
- Commit, in CLEAR:
  - A frame-start edge sets pend instead of committing.
  - The first edge in IDLE with pend set commits the fully cleared shadow and clears pend.
- oCOMMIT is high the cycle after any commit edge.

## Timing
- Reset values:
  - Outputs: oGRID=0, oA_ACK=0, oB_ACK=0, oBUSY=0, oCOMMIT=0.
  - Internal: shadow=0, state IDLE, pend=0, pointer→A, vd_q=1.
- Reset asserted mid-clear aborts the clear immediately. No oB_ACK is issued for the aborted clear.
- A write, iVD fall → visible on oGRID: latency 1 edge from the frame-start edge.
- Clear acceptance → oB_ACK: COLS cycles (12). oBUSY is high for exactly 12 cycles.
- Per-port throughput: one request per 2 cycles (grant edge, then the ACK cycle).
- Both ports requesting continuously: grants alternate A, B, A, ….
- A clear requested by B while A is eligible follows normal round-robin.
- Frame start coinciding with the last CLEAR edge: treated as pend. The commit occurs on the next edge (IDLE), and oCOMMIT follows one cycle later.
- The first iVD low after reset (vd_q=1) commits; this is harmless because the shadow is all zeros.

## Structure
- Package lcd_grid_pkg: COLS, ROWS, GRID_W=COLS·ROWS, COL_W=4, ROW_W=3, state enum {ST_IDLE, ST_CLEAR}.
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: eligible vector, advance enable.
  - Outputs: one-hot grant; registered last-grant pointer with synchronous active-high reset.
- Top level holds the FSM, shadow, display register, pend and the vsync edge detector.

## Test plan
- Reset, then A writes COL=3, ROW=5, VAL=1 → oA_ACK one cycle; oGRID bit 29 stays 0 until the next iVD fall; oGRID=1<<29 one edge after the fall; oCOMMIT pulses.
- A and B request together and hold: A COL=0/ROW=0, B COL=11/ROW=7 → A acked first, B two cycles later; after commit, oGRID bits 0 and 95 set.
- Grid all ones, B clear; iVD falls on the 5th CLEAR cycle → oBUSY high 12 cycles; oB_ACK after cycle 12; commit deferred; oGRID goes straight to 0, never partially cleared.
- A writes COL=12 → oA_ACK pulses; shadow and oGRID unchanged after commit.
- A write granted on the same edge as the iVD fall → the current commit excludes it; the following frame's commit includes it.
- iRST asserted on CLEAR cycle 6 → next cycle: oBUSY=0, oGRID=0, no oB_ACK; a new A request is granted normally.

Source files
------------

// File: rtl/lcd_grid_pkg.sv
// Shared sizes and FSM state type for the LCD overlay grid arbiter.
// The grid is COLS columns of ROWS bits, flattened column-major.
package lcd_grid_pkg;

  localparam int COLS   = 12;
  localparam int ROWS   = 8;
  localparam int GRID_W = COLS * ROWS;
  localparam int COL_W  = 4;
  localparam int ROW_W  = 3;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

endpackage

// File: rtl/lcd_grid_update_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is port A and bit 1 is port B.
// A registered pointer remembers the last winner; after reset it favours A.
module rr_arb2 (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [1:0] elig,
  input  logic       adv,
  output logic [1:0] grant
);

  // Set when B won last, so A wins the next tie.
  logic last_b_reg;

  always_comb begin
    grant = 2'b00;
    if (adv) begin
      case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_b_reg ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      last_b_reg <= 1'b1;
    end else if (|grant) begin
      last_b_reg <= grant[1];
    end
  end

endmodule

// File: rtl/lcd_grid_update_arbiter.sv
// Overlay grid owner: arbitrates touch (A) and host (B) writes into a shadow grid
// and copies the shadow to the displayed grid at each vsync frame start.
module lcd_grid_update_arbiter
  import lcd_grid_pkg::*;
(
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iVD,
  input  logic              iA_REQ,
  input  logic [COL_W-1:0]  iA_COL,
  input  logic [ROW_W-1:0]  iA_ROW,
  input  logic              iA_VAL,
  output logic              oA_ACK,
  input  logic              iB_REQ,
  input  logic              iB_CLR,
  input  logic [COL_W-1:0]  iB_COL,
  input  logic [ROW_W-1:0]  iB_ROW,
  input  logic              iB_VAL,
  output logic              oB_ACK,
  output logic [GRID_W-1:0] oGRID,
  output logic              oBUSY,
  output logic              oCOMMIT
);

  state_t             state_reg, state_next;
  logic [COL_W-1:0]   cnt_reg, cnt_next;
  logic               pend_reg, pend_next;
  logic               a_ack_reg, a_ack_next;
  logic               b_ack_reg, b_ack_next;
  logic               commit_reg, commit_next;
  logic [GRID_W-1:0]  grid_reg, grid_next;
  logic               vd_q_reg;

  logic [ROWS-1:0]    shadow_reg [COLS];
  logic [GRID_W-1:0]  shadow_flat;

  logic [1:0]         elig;
  logic [1:0]         grant;
  logic               frame_start;
  logic               wr_en;
  logic               clr_en;
  logic [COL_W-1:0]   wr_col;
  logic [ROW_W-1:0]   wr_row;
  logic               wr_val;

  // A port stays ineligible during its ACK cycle so a held REQ is not granted twice.
  assign elig        = {iB_REQ & ~b_ack_reg, iA_REQ & ~a_ack_reg};
  assign frame_start = vd_q_reg & ~iVD;

  rr_arb2 u_arb (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .elig  (elig),
    .adv   (state_reg == ST_IDLE),
    .grant (grant)
  );

  assign wr_en  = grant[0] | (grant[1] & ~iB_CLR);
  assign wr_col = grant[0] ? iA_COL : iB_COL;
  assign wr_row = grant[0] ? iA_ROW : iB_ROW;
  assign wr_val = grant[0] ? iA_VAL : iB_VAL;
  assign clr_en = (state_reg == ST_CLEAR);

  // Out-of-range columns match no generate slot, so such writes are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      always_ff @(posedge iCLK) begin
        if (iRST) begin
          shadow_reg[gi] <= '0;
        end else if (clr_en && (cnt_reg == COL_W'(gi))) begin
          shadow_reg[gi] <= '0;
        end else if (wr_en && (wr_col == COL_W'(gi))) begin
          shadow_reg[gi][wr_row] <= wr_val;
        end
      end
      assign shadow_flat[gi*ROWS +: ROWS] = shadow_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    pend_next   = pend_reg;
    a_ack_next  = 1'b0;
    b_ack_next  = 1'b0;
    commit_next = 1'b0;
    grid_next   = grid_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant[0]) begin
          a_ack_next = 1'b1;
        end
        if (grant[1]) begin
          if (iB_CLR) begin
            state_next = ST_CLEAR;
            cnt_next   = '0;
          end else begin
            b_ack_next = 1'b1;
          end
        end
        // Commit uses the pre-edge shadow; a write on this edge shows next frame.
        if (frame_start || pend_reg) begin
          grid_next   = shadow_flat;
          pend_next   = 1'b0;
          commit_next = 1'b1;
        end
      end
      ST_CLEAR: begin
        cnt_next = cnt_reg + COL_W'(1);
        if (frame_start) begin
          pend_next = 1'b1;
        end
        if (cnt_reg == COL_W'(COLS - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          b_ack_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      pend_reg   <= 1'b0;
      a_ack_reg  <= 1'b0;
      b_ack_reg  <= 1'b0;
      commit_reg <= 1'b0;
      grid_reg   <= '0;
      vd_q_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      pend_reg   <= pend_next;
      a_ack_reg  <= a_ack_next;
      b_ack_reg  <= b_ack_next;
      commit_reg <= commit_next;
      grid_reg   <= grid_next;
      vd_q_reg   <= iVD;
    end
  end

  assign oA_ACK  = a_ack_reg;
  assign oB_ACK  = b_ack_reg;
  assign oGRID   = grid_reg;
  assign oBUSY   = (state_reg == ST_CLEAR);
  assign oCOMMIT = commit_reg;

endmodule

// File: tb/tb_lcd_grid_update_arbiter.sv
// Scoreboard bench for lcd_grid_update_arbiter: expected acks and committed grids
// are queued as stimulus is driven and popped by a monitor when the DUT emits them.
module tb_lcd_grid_update_arbiter;

  logic        iCLK;
  logic        iRST;
  logic        iVD;
  logic        iA_REQ;
  logic [3:0]  iA_COL;
  logic [2:0]  iA_ROW;
  logic        iA_VAL;
  logic        oA_ACK;
  logic        iB_REQ;
  logic        iB_CLR;
  logic [3:0]  iB_COL;
  logic [2:0]  iB_ROW;
  logic        iB_VAL;
  logic        oB_ACK;
  logic [95:0] oGRID;
  logic        oBUSY;
  logic        oCOMMIT;

  int n_checks = 0;
  int n_err    = 0;

  logic [95:0] model;
  logic [95:0] grid_disp;
  logic [95:0] grid_q[$];
  logic        ack_q[$];

  lcd_grid_update_arbiter dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iVD     (iVD),
    .iA_REQ  (iA_REQ),
    .iA_COL  (iA_COL),
    .iA_ROW  (iA_ROW),
    .iA_VAL  (iA_VAL),
    .oA_ACK  (oA_ACK),
    .iB_REQ  (iB_REQ),
    .iB_CLR  (iB_CLR),
    .iB_COL  (iB_COL),
    .iB_ROW  (iB_ROW),
    .iB_VAL  (iB_VAL),
    .oB_ACK  (oB_ACK),
    .oGRID   (oGRID),
    .oBUSY   (oBUSY),
    .oCOMMIT (oCOMMIT)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; the monitor samples at 1.
  task automatic tick();
    @(posedge iCLK);
    #2;
  endtask

  always begin
    @(posedge iCLK);
    #1;
    if (!iRST) begin
      if (oA_ACK) begin
        if (ack_q.size() == 0) chk("ack_unexpected_A", 96'd1, 96'd0);
        else chk("ack_port_A", 96'(1'b0), 96'(ack_q.pop_front()));
        $display("[%0t] ack port A", $time);
      end
      if (oB_ACK) begin
        if (ack_q.size() == 0) chk("ack_unexpected_B", 96'd1, 96'd0);
        else chk("ack_port_B", 96'(1'b1), 96'(ack_q.pop_front()));
        $display("[%0t] ack port B", $time);
      end
      if (oCOMMIT) begin
        if (grid_q.size() == 0) chk("commit_unexpected", 96'd1, 96'd0);
        else chk("commit_grid", oGRID, grid_q.pop_front());
        $display("[%0t] commit grid=%h", $time, oGRID);
      end
    end
  end

  task automatic a_write(input logic [3:0] col, input logic [2:0] row, input logic val);
    int n;
    iA_COL = col; iA_ROW = row; iA_VAL = val; iA_REQ = 1'b1;
    ack_q.push_back(1'b0);
    n = 0;
    do begin tick(); n++; end while (!oA_ACK && n < 20);
    chk("a_ack_seen", 96'(oA_ACK), 96'd1);
    iA_REQ = 1'b0;
    if (col < 4'd12) model[{col, row}] = val;
  endtask

  task automatic b_write(input logic [3:0] col, input logic [2:0] row, input logic val);
    int n;
    iB_COL = col; iB_ROW = row; iB_VAL = val; iB_CLR = 1'b0; iB_REQ = 1'b1;
    ack_q.push_back(1'b1);
    n = 0;
    do begin tick(); n++; end while (!oB_ACK && n < 20);
    chk("b_ack_seen", 96'(oB_ACK), 96'd1);
    iB_REQ = 1'b0;
    if (col < 4'd12) model[{col, row}] = val;
  endtask

  task automatic frame();
    iVD = 1'b0;
    grid_q.push_back(model);
    tick();
    chk("commit_pulse", 96'(oCOMMIT), 96'd1);
    chk("grid_after_vd", oGRID, model);
    grid_disp = model;
    tick();
    chk("commit_one_cycle", 96'(oCOMMIT), 96'd0);
    tick();
    iVD = 1'b1;
    tick();
    tick();
  endtask

  // Issues a clear; drops iVD on busy cycle vd_at, or resets on busy cycle rst_at (0 = never).
  task automatic b_clear(input int vd_at, input int rst_at);
    int  busy;
    bit  done;
    bit  vd_sent;
    iB_CLR = 1'b1; iB_REQ = 1'b1;
    if (rst_at == 0) ack_q.push_back(1'b1);
    busy = 0; done = 1'b0; vd_sent = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      tick();
      if (oBUSY) begin
        busy++;
        chk("grid_during_clear", oGRID, grid_disp);
        chk("no_commit_in_clear", 96'(oCOMMIT), 96'd0);
      end
      if (vd_at > 0 && busy == vd_at && !vd_sent) begin
        iVD = 1'b0;
        grid_q.push_back(96'd0);
        vd_sent = 1'b1;
      end
      if (rst_at > 0 && busy == rst_at) begin
        iRST = 1'b1; iB_REQ = 1'b0; iB_CLR = 1'b0;
        tick();
        iRST = 1'b0;
        chk("rst_busy", 96'(oBUSY), 96'd0);
        chk("rst_grid", oGRID, 96'd0);
        chk("rst_no_back", 96'(oB_ACK), 96'd0);
        tick();
        chk("rst_no_back_later", 96'(oB_ACK), 96'd0);
        model = '0; grid_disp = '0;
        done = 1'b1;
      end else if (oB_ACK) begin
        iB_REQ = 1'b0; iB_CLR = 1'b0;
        chk("clear_busy_cycles", 96'(busy), 96'd12);
        chk("busy_low_at_ack", 96'(oBUSY), 96'd0);
        done = 1'b1;
      end
    end
    chk("clear_done", 96'(done), 96'd1);
    model = '0;
  endtask

  initial begin
    int ta, tb;
    iRST = 1'b1; iVD = 1'b1;
    iA_REQ = 0; iA_COL = 0; iA_ROW = 0; iA_VAL = 0;
    iB_REQ = 0; iB_CLR = 0; iB_COL = 0; iB_ROW = 0; iB_VAL = 0;
    model = '0; grid_disp = '0;
    repeat (3) tick();
    iRST = 1'b0;
    tick();
    chk("rst_grid", oGRID, 96'd0);
    chk("rst_a_ack", 96'(oA_ACK), 96'd0);
    chk("rst_b_ack", 96'(oB_ACK), 96'd0);
    chk("rst_busy", 96'(oBUSY), 96'd0);
    chk("rst_commit", 96'(oCOMMIT), 96'd0);

    // Single A write, visible only after the frame start.
    a_write(4'd3, 3'd5, 1'b1);
    tick();
    chk("a_ack_one_cycle", 96'(oA_ACK), 96'd0);
    chk("grid_before_vd", oGRID, 96'd0);
    frame();
    chk("bit29_only", oGRID, 96'd1 << 29);

    // B write so the pointer favours A for the contended case.
    b_write(4'd1, 3'd0, 1'b0);
    tick();

    // Both ports request together and hold.
    iA_COL = 4'd0;  iA_ROW = 3'd0; iA_VAL = 1'b1; iA_REQ = 1'b1;
    iB_COL = 4'd11; iB_ROW = 3'd7; iB_VAL = 1'b1; iB_CLR = 1'b0; iB_REQ = 1'b1;
    ack_q.push_back(1'b0); ack_q.push_back(1'b1);
    ta = 0; tb = 0;
    for (int n = 1; n <= 10 && (ta == 0 || tb == 0); n++) begin
      tick();
      if (oA_ACK) begin ta = n; iA_REQ = 1'b0; end
      if (oB_ACK) begin tb = n; iB_REQ = 1'b0; end
    end
    chk("contend_a_cycle", 96'(ta), 96'd1);
    chk("contend_b_cycle", 96'(tb), 96'd2);
    model[0] = 1'b1; model[95] = 1'b1;
    tick();
    frame();

    // Fill the grid with ones, then clear with a frame start on busy cycle 5.
    for (int c = 0; c < 12; c++)
      for (int r = 0; r < 8; r++)
        a_write(4'(c), 3'(r), 1'b1);
    tick();
    frame();
    b_clear(5, 0);
    chk("grid_held_at_ack", oGRID, {96{1'b1}});
    tick();
    chk("deferred_commit", 96'(oCOMMIT), 96'd1);
    chk("grid_cleared", oGRID, 96'd0);
    grid_disp = '0;
    tick();
    iVD = 1'b1;
    tick(); tick();

    // Out-of-range column is acked but changes nothing.
    a_write(4'd12, 3'd2, 1'b1);
    tick();
    frame();
    chk("col12_no_effect", oGRID, 96'd0);

    // Write granted on the frame-start edge lands in the next frame.
    iA_COL = 4'd2; iA_ROW = 3'd1; iA_VAL = 1'b1; iA_REQ = 1'b1;
    iVD = 1'b0;
    ack_q.push_back(1'b0);
    grid_q.push_back(model);
    tick();
    chk("same_edge_ack", 96'(oA_ACK), 96'd1);
    chk("same_edge_commit", 96'(oCOMMIT), 96'd1);
    chk("same_edge_excluded", oGRID, 96'd0);
    iA_REQ = 1'b0;
    model[17] = 1'b1;
    tick(); tick();
    iVD = 1'b1;
    tick();
    frame();
    chk("next_frame_bit17", oGRID, 96'd1 << 17);

    // Reset on clear cycle 6 aborts without oB_ACK, then A works normally.
    b_clear(0, 6);
    a_write(4'd4, 3'd2, 1'b1);
    tick();
    frame();
    chk("post_reset_bit34", oGRID, 96'd1 << 34);

    repeat (3) tick();
    chk("ack_q_drained", 96'(ack_q.size()), 96'd0);
    chk("grid_q_drained", 96'(grid_q.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
